bcd_6d_to_bin_20b_serial: RTL and testbench
===========================================

Name: bcd_6d_to_bin_20b_serial

Overview:
- Iterative converter from a 6-digit packed BCD value to a 20-bit unsigned binary value. It is the inverse of the 20-bit-to-BCD display decoder.
- It sits between the keypad/digit-entry logic, which holds operands as BCD digits, and the binary arithmetic datapath.
- It processes one digit per clock using acc = acc*10 + digit, most significant digit first.
- Valid/ready handshake on both the input and output sides.

Parameters:
- DIGITS, 6, number of BCD digits on the input.
- N, 20, output binary width. Must satisfy 2^N > 10^DIGITS - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bcd is valid this cycle.
- in_ready  output  1  converter can accept a new value.
- in_bcd  input  4*DIGITS  packed BCD. Bits [23:20] are hundred-thousands, bits [3:0] are units.
- out_valid  output  1  out_bin and out_err hold a finished result.
- out_ready  input  1  consumer takes the result.
- out_bin  output  N  binary result.
- out_err  output  1  an input digit was >9 (only when BCD_CHECK_EN is defined; otherwise tied 0).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, acc=0, cnt=0.
  - out_valid=0, out_bin=0, out_err=0.
  - in_ready=1 as soon as reset is released.
- in_ready = (state==IDLE), decoded combinationally from state. It is 0 during CONV and DONE; there is no overlap of jobs.
- IDLE:
  - On the edge where in_valid&&in_ready: capture in_bcd into the shift register, acc=0, cnt=0, go to CONV.
- CONV:
  - Each edge: acc = (acc<<3)+(acc<<1)+digit, then the shift register moves left by 4 bits, cnt++. Digit is the top nibble of the shift register.
  - Arithmetic is modulo 2^N; the 4-bit digit is zero-extended.
  - On the edge where cnt reaches DIGITS-1: go to DONE, out_bin=final acc, out_valid=1.
- Latency: out_valid rises exactly DIGITS (6) edges after the accept edge.
- DONE:
  - out_bin and out_err are held stable while out_ready=0.
  - On the edge where out_valid&&out_ready: out_valid=0, go to IDLE. in_ready=1 in the following cycle.
  - A new input can never be accepted on the same edge as the output handshake.
- in_valid during CONV/DONE is ignored (no capture). in_bcd is sampled only on the accept edge; later changes have no effect.
- out_bin is only updated on the transition to DONE. Between jobs it keeps the last result; consumers qualify it with out_valid.
- Reset mid-operation (any state): immediate abort to reset values. No partial result is ever presented.

Optional Feature:
- Macro BCD_CHECK_EN.
- Defined:
  - On the accept edge, a sticky error bit is set if any captured nibble >9.
  - On entering DONE: out_err=error bit, and out_bin is forced to 0 if the error bit is set.
  - The error bit is cleared on the next accept and on reset.
- Not defined:
  - out_err is constant 0.
  - Nibbles 10..15 are used arithmetically as-is, result modulo 2^N (e.g. 0x00000A gives 10).

Decomposition:
- Shared package holds:
  - state typedef {IDLE, CONV, DONE} with 2-bit encoding.
  - DIGIT_W=4 and BCD_MAX=4'd9.
  - Default DIGITS/N constants shared with the 20-bit-to-BCD decoder.
- One natural combinational sub-module, bcd_mac10: computes acc*10+digit at width N using shift-add only, no multiplier.

Test Plan:
- Convert 123456: send in_bcd=24'h123456 with out_ready=1 -> out_valid exactly 6 cycles after accept, out_bin=20'h1E240, out_err=0.
- Boundary values: 24'h999999 -> 20'hF423F; 24'h000000 -> 20'h00000; 24'h000001 -> 20'h00001.
- Backpressure: send 24'h000042 with out_ready=0 for 5 cycles after out_valid -> out_bin=20'h0002A stable, in_ready=0 throughout; out_ready=1 -> out_valid falls next edge, in_ready=1 the cycle after.
- Input ignored while busy: send 24'h000500 during CONV -> not captured, no extra out_valid pulse; result stays that of the first job.
- Reset mid-conversion: assert rst_n=0 at cnt=3 -> out_valid=0, out_bin=0, in_ready=1 after release; a following 24'h000007 converts to 20'h00007.
- Invalid digit 24'h00000A:
  - with BCD_CHECK_EN -> out_err=1, out_bin=0.
  - without BCD_CHECK_EN -> out_err=0, out_bin=20'h0000A.

Source files
------------

// File: rtl/bcd_6d_to_bin_20b_serial_pkg.sv
// Shared constants, state type and digit helpers for the serial BCD-to-binary converter
// and its companion 20-bit-to-BCD display decoder.
package bcd_6d_to_bin_20b_serial_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam int unsigned DEF_DIGITS = 6;
  localparam int unsigned DEF_N      = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction

  // Elaboration-time helper used to check that N bits can hold 10^DIGITS-1.
  function automatic longint unsigned pow10(input int unsigned e);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < e; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_6d_to_bin_20b_serial_if.sv
// Input/output valid-ready bundle of the serial BCD-to-binary converter.
interface bcd_6d_to_bin_20b_serial_if
  import bcd_6d_to_bin_20b_serial_pkg::*;
#(
  parameter int unsigned DIGITS = DEF_DIGITS,
  parameter int unsigned N      = DEF_N
);

  logic                        in_valid;
  logic                        in_ready;
  logic [DIGIT_W*DIGITS-1:0]   in_bcd;
  logic                        out_valid;
  logic                        out_ready;
  logic [N-1:0]                out_bin;
  logic                        out_err;

  modport master (
    output in_valid,
    input  in_ready,
    output in_bcd,
    input  out_valid,
    output out_ready,
    input  out_bin,
    input  out_err
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_bcd,
    output out_valid,
    input  out_ready,
    output out_bin,
    output out_err
  );

endinterface

// File: rtl/bcd_6d_to_bin_20b_serial_bcd_mac10.sv
// Combinational acc*10 + digit step at width N, built from two shifted adds.
module bcd_mac10
  import bcd_6d_to_bin_20b_serial_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic [N-1:0]       acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [N-1:0]       result
);

  logic [N-1:0] acc_x8;
  logic [N-1:0] acc_x2;

  assign acc_x8 = acc << 3;
  assign acc_x2 = acc << 1;
  assign result = acc_x8 + acc_x2 + N'(digit);

endmodule

// File: rtl/bcd_6d_to_bin_20b_serial.sv
// Iterative packed-BCD to binary converter, one digit per clock, MSD first.
// Optional digit validation is enabled by defining BCD_CHECK_EN.
module bcd_6d_to_bin_20b_serial
  import bcd_6d_to_bin_20b_serial_pkg::*;
#(
  parameter int unsigned DIGITS = DEF_DIGITS,
  parameter int unsigned N      = DEF_N
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bcd_6d_to_bin_20b_serial_if.slave    bus
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  if (N < 64) begin : g_width_check
    if ((64'd1 << N) <= (pow10(DIGITS) - 64'd1)) begin : g_too_narrow
      $error("N is too narrow for DIGITS decimal digits");
    end
  end

  state_t             state;
  logic [BCD_W-1:0]   sreg;
  logic [N-1:0]       acc;
  logic [N-1:0]       acc_nxt;
  logic [N-1:0]       bin_final;
  logic [N-1:0]       bin_q;
  logic [CNT_W-1:0]   cnt;
  logic               valid_q;
  logic               accept;
  logic               release_out;
  logic               last_digit;

  assign accept      = bus.in_valid && (state == IDLE);
  assign release_out = valid_q && bus.out_ready;
  assign last_digit  = (cnt == CNT_W'(DIGITS - 1));

  bcd_mac10 #(.N(N)) u_mac10 (
    .acc    (acc),
    .digit  (sreg[BCD_W-1 -: DIGIT_W]),
    .result (acc_nxt)
  );

`ifdef BCD_CHECK_EN
  logic bad_any;
  logic err_q;
  logic err_out_q;

  always_comb begin
    bad_any = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_invalid(bus.in_bcd[i*DIGIT_W +: DIGIT_W])) bad_any = 1'b1;
    end
  end

  // Sticky flag is latched at accept; it only reaches the output on entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      if (accept) err_q <= bad_any;
      if (state == CONV && last_digit) err_out_q <= err_q;
    end
  end

  assign bin_final   = err_q ? '0 : acc_nxt;
  assign bus.out_err = err_out_q;
`else
  assign bin_final   = acc_nxt;
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      bin_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= bus.in_bcd;
            acc   <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          acc  <= acc_nxt;
          sreg <= sreg << DIGIT_W;
          cnt  <= cnt + CNT_W'(1);
          if (last_digit) begin
            bin_q   <= bin_final;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (release_out) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_bin   = bin_q;

endmodule

// File: tb/tb_bcd_6d_to_bin_20b_serial.sv
// Self-checking bench for bcd_6d_to_bin_20b_serial: vector table, scoreboard queue,
// plus backpressure, busy-input, and mid-conversion reset sequences.
module tb_bcd_6d_to_bin_20b_serial;
  import bcd_6d_to_bin_20b_serial_pkg::*;

  localparam int unsigned DIGITS = 6;
  localparam int unsigned N      = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_6d_to_bin_20b_serial_if #(.DIGITS(DIGITS), .N(N)) bus ();

  bcd_6d_to_bin_20b_serial #(.DIGITS(DIGITS), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] bcd;
    logic [19:0] bin;
    logic        err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [19:0] bin;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[9];
  int          n_cmp   = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: weighted digit sum, LSD first, truncated to N bits.
  function automatic logic [19:0] model(input logic [23:0] bcd);
    longint unsigned sum;
    longint unsigned w;
    sum = 0;
    w   = 1;
    for (int k = 0; k < 6; k++) begin
      sum = sum + longint'(bcd[4*k +: 4]) * w;
      w   = w * 10;
    end
    return sum[19:0];
  endfunction

  task automatic send(input logic [23:0] bcd, input exp_t e);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_bcd   = bcd;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    sb.push_back(e);
    bus.in_valid = 1'b0;
    bus.in_bcd   = 24'($urandom);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   t;
    t = 0;
    bus.out_ready = (hold == 0);
    while (!bus.out_valid && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("out_valid_rise", bus.out_valid, 1);
    check("latency", cyc - acc_cyc, DIGITS);
    check("scoreboard_depth", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e.bin = '0;
      e.err = 1'b0;
    end
    check("out_bin", bus.out_bin, e.bin);
    check("out_err", bus.out_err, e.err);
    check("in_ready_done", bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_out_bin", bus.out_bin, e.bin);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_fall", bus.out_valid, 0);
    check("in_ready_after_handshake", bus.in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [23:0] r;
    logic        seen;

    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b1;

    tbl[0] = '{24'h123456, 20'h1E240, 1'b0, 0};
    tbl[1] = '{24'h999999, 20'hF423F, 1'b0, 0};
    tbl[2] = '{24'h000000, 20'h00000, 1'b0, 0};
    tbl[3] = '{24'h000001, 20'h00001, 1'b0, 0};
    tbl[4] = '{24'h000042, 20'h0002A, 1'b0, 5};
    tbl[5] = '{24'h100000, 20'h186A0, 1'b0, 0};
    tbl[6] = '{24'h098765, 20'h181CD, 1'b0, 2};
    tbl[7] = '{24'h543210, 20'h849EA, 1'b0, 0};
`ifdef BCD_CHECK_EN
    tbl[8] = '{24'h00000A, 20'h00000, 1'b1, 0};
`else
    tbl[8] = '{24'h00000A, 20'h0000A, 1'b0, 0};
`endif

    #23;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_bin", bus.out_bin, 0);
    check("reset_out_err", bus.out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      e.bin = tbl[i].bin;
      e.err = tbl[i].err;
      send(tbl[i].bcd, e);
      collect(tbl[i].hold);
    end

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 6; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
      e.bin = model(r);
      e.err = 1'b0;
      send(r, e);
      collect(i % 2);
    end

    // Second request while converting must be ignored.
    e.bin = 20'h0007B;
    e.err = 1'b0;
    send(24'h000123, e);
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 24'h000500;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    collect(0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("busy_no_extra_out_valid", seen, 0);
    check("busy_scoreboard_empty", sb.size(), 0);

    // Reset in the middle of a conversion.
    e.bin = 20'h003E7;
    e.err = 1'b0;
    send(24'h000999, e);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_out_bin", bus.out_bin, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("midreset_no_partial", seen, 0);
    e.bin = 20'h00007;
    e.err = 1'b0;
    send(24'h000007, e);
    collect(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
